// File: rtl/lcd_value_scheduler.sv
// lcd_value_scheduler
// Shows a 32-bit unsigned reading as 10 decimal digits on an HD44780 character display.
// The reading is converted to BCD by iterative double-dabble. Then one DDRAM-address command
// and 10 character writes are pushed through the lcd driver's data_ready/busy_flag handshake.
// Requests that arrive mid-update are held in a single pending slot, where the newest value wins.
// The pending value is replayed once the current update finishes.

module lcd_value_scheduler #(
   parameter logic [7:0] DDRAM_ADDR  = 8'h80,
   parameter bit         BLANK_ZEROS = 1'b1,
   parameter int         ACK_TIMEOUT = 1000
) (
   input  logic        clock,
   input  logic        internal_reset,
   input  logic [31:0] value,
   input  logic        value_valid,
   input  logic        lcd_busy,
   output logic [8:0]  lcd_word,
   output logic        data_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      ISSUE,
      ACK,
      FREE
   } state_t;

   localparam logic [15:0] TIMER_LIMIT = 16'(ACK_TIMEOUT - 1);

   state_t      state;
   logic        pending;
   logic [31:0] pending_value;
   logic [31:0] shift_reg;
   logic [39:0] bcd;
   logic [4:0]  conv_count;
   logic [3:0]  index;
   logic [15:0] timer;
   logic [8:0]  item_word;
   logic        all_zero;
   logic [3:0]  digit;

   // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
   function automatic logic [39:0] dabble_step(input logic [39:0] b, input logic in_bit);
      logic [39:0] r;
      r = b;
      for (int d = 0; d < 10; d++) begin
         if (r[d*4 +: 4] >= 4'd5)
            r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
      end
      return {r[38:0], in_bit};
   endfunction

   // Build the byte for the current item: the address command first, then digits MS first.
   // Leading zeros may be blanked, but the last digit always shows so zero reads as "0".
   always_comb begin
      item_word = {1'b0, DDRAM_ADDR};
      all_zero  = 1'b1;
      digit     = 4'd0;
      for (int k = 1; k <= 10; k++) begin
         digit    = bcd[(10-k)*4 +: 4];
         all_zero = all_zero & (digit == 4'd0);
         if (index == 4'(k)) begin
            if (BLANK_ZEROS && all_zero && (k < 10))
               item_word = 9'h120;
            else
               item_word = {1'b1, 4'h3, digit};
         end
      end
   end

   // Main sequencer: request buffering, conversion, and the per-item lcd handshake.
   // The strobes done and timeout_err default low, so each one lasts a single cycle.
   always_ff @(posedge clock or posedge internal_reset) begin
      if (internal_reset) begin
         state         <= IDLE;
         lcd_word      <= 9'h000;
         data_ready    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         timeout_err   <= 1'b0;
         pending       <= 1'b0;
         pending_value <= 32'd0;
         shift_reg     <= 32'd0;
         bcd           <= 40'd0;
         conv_count    <= 5'd0;
         index         <= 4'd0;
         timer         <= 16'd0;
      end else begin
         done        <= 1'b0;
         timeout_err <= 1'b0;

         if (state != IDLE && value_valid) begin
            pending_value <= value;
            pending       <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (pending) begin
                  shift_reg <= pending_value;
                  if (value_valid)
                     pending_value <= value;
                  else
                     pending <= 1'b0;
                  bcd        <= 40'd0;
                  conv_count <= 5'd0;
                  busy       <= 1'b1;
                  state      <= CONV;
               end else if (value_valid) begin
                  shift_reg  <= value;
                  bcd        <= 40'd0;
                  conv_count <= 5'd0;
                  busy       <= 1'b1;
                  state      <= CONV;
               end
            end

            CONV: begin
               bcd        <= dabble_step(bcd, shift_reg[31]);
               shift_reg  <= {shift_reg[30:0], 1'b0};
               conv_count <= conv_count + 5'd1;
               if (conv_count == 5'd31) begin
                  index <= 4'd0;
                  state <= ISSUE;
               end
            end

            ISSUE: begin
               if (!lcd_busy) begin
                  lcd_word   <= item_word;
                  data_ready <= 1'b1;
                  timer      <= 16'd0;
                  state      <= ACK;
               end
            end

            ACK: begin
               if (lcd_busy) begin
                  data_ready <= 1'b0;
                  state      <= FREE;
               end else if (timer >= TIMER_LIMIT) begin
                  data_ready  <= 1'b0;
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else if (timer != 16'hFFFF) begin
                  timer <= timer + 16'd1;
               end
            end

            FREE: begin
               if (!lcd_busy) begin
                  if (index == 4'd10) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     index <= index + 4'd1;
                     state <= ISSUE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
